// File: rtl/instruction_cache_dm.sv
// Direct-mapped, read-only instruction cache for the IF stage.
// Hits respond one cycle after the request. Misses refill a whole line before returning the word.
module instruction_cache_dm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic                  fetch_req,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instr_valid,
   output logic                  stall,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W - 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

   state_t state, next_state;

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             unused_pc_bits;

   assign pc_off         = PC[OFF_W+1:2];
   assign pc_idx         = PC[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag         = PC[ADDR_WIDTH-1:OFF_W+IDX_W+2];
   assign unused_pc_bits = ^PC[1:0];

   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
   logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0]  valid_q;

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [OFF_W-1:0]      req_off;
   logic [OFF_W-1:0]      word_cnt;
   logic [DATA_WIDTH-1:0] resp_word;
   logic                  flush_pend;

   logic hit, accept, beat, last_beat;

   assign hit       = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign accept    = (state == IDLE) && fetch_req && !flush;
   assign beat      = (state == FILL) && mem_rvalid;
   assign last_beat = beat && (word_cnt == LAST_WORD);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept && !hit) next_state = REQ;
         REQ:     if (mem_ready)      next_state = FILL;
         FILL:    if (last_beat)      next_state = RESP;
         RESP:                        next_state = IDLE;
         default:                     next_state = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      stall    = 1'b0;
      mem_req  = 1'b0;
      mem_addr = '0;
      unique case (state)
         REQ: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
         end
         FILL:    stall = 1'b1;
         default: ;
      endcase
   end

   // NOTE: data and tag arrays are not reset; valid_q alone qualifies their contents.
   always_ff @(posedge clock) begin
      if (beat)      data_mem[{req_idx, word_cnt}] <= mem_rdata;
      if (last_beat) tag_mem[req_idx]              <= req_tag;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= '0;
         instruction <= '0;
         instr_valid <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         req_tag     <= '0;
         req_idx     <= '0;
         req_off     <= '0;
         word_cnt    <= '0;
         resp_word   <= '0;
         flush_pend  <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               flush_pend <= 1'b0;
               if (accept) begin
                  if (hit) begin
                     instruction <= data_mem[{pc_idx, pc_off}];
                     instr_valid <= 1'b1;
                     if (hit_count != '1) hit_count <= hit_count + 32'd1;
                  end else begin
                     req_tag  <= pc_tag;
                     req_idx  <= pc_idx;
                     req_off  <= pc_off;
                     word_cnt <= '0;
                     if (miss_count != '1) miss_count <= miss_count + 32'd1;
                  end
               end
            end
            REQ: if (flush) flush_pend <= 1'b1;
            FILL: begin
               if (flush) flush_pend <= 1'b1;
               if (beat) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == req_off) resp_word <= mem_rdata;
                  // A flush seen at any point of the refill keeps the new line invalid.
                  if (last_beat && !flush_pend && !flush) valid_q[req_idx] <= 1'b1;
               end
            end
            RESP: begin
               instruction <= resp_word;
               instr_valid <= 1'b1;
            end
            default: ;
         endcase
         if (flush) valid_q <= '0;
      end
   end

endmodule
